nf10_eee_lpi_scheduler: RTL and testbench
=========================================

# nf10_eee_lpi_scheduler

- Sequences 802.3az Energy-Efficient Ethernet low-power idle on one 10G transmit path.
- Sits between the output port lookup and the TX queue as an AXI4-Stream stage:
  - passes traffic through while active;
  - counts idle time, then runs SLEEP/LPI/WAKE;
  - holds traffic back while the link is not awake.
- Drives the PHY LPI request and exposes its state to software.

## Interface
- C_DATA_WIDTH, 256, tdata width; tstrb is C_DATA_WIDTH/8.
- C_TUSER_WIDTH, 128, tuser width.
- IDLE_CYCLES, 64, idle cycles required in ACTIVE before LPI entry (1..65535).
- TS_CYCLES, 461, SLEEP duration in cycles (1..65535).
- TW_CYCLES, 6349, WAKE duration in cycles (1..65535).
- axi_aclk  in  1  single clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata / tstrb / tuser  in  C_DATA_WIDTH / C_DATA_WIDTH/8 / C_TUSER_WIDTH  upstream beat.
- s_axis_tvalid, s_axis_tlast  in  1 each.
- s_axis_tready  out  1.
- m_axis_tdata / tstrb / tuser  out  same widths as the s_axis fields  downstream beat.
- m_axis_tvalid, m_axis_tlast  out  1 each.
- m_axis_tready  in  1.
- lpi_en  in  1  software enable for LPI entry.
- tx_lpi  out  1  LPI request to the PHY.
- lpi_state  out  2  state encoding: 00 ACTIVE, 01 SLEEP, 10 LPI, 11 WAKE.
- lpi_cycles  out  32  cycles spent in LPI (statistics).
- lpi_entries  out  16  number of SLEEP entries (statistics).

## Operation
- States ACTIVE, SLEEP, LPI, WAKE. Reset state is ACTIVE.
- ACTIVE: combinational pass-through.
  - m_axis_{tdata,tstrb,tuser,tlast,tvalid} = s_axis_*.
  - s_axis_tready = m_axis_tready.
  - tx_lpi = 0.
- All other states:
  - m_axis_tvalid = 0, s_axis_tready = 0.
  - m_axis data fields still mirror s_axis (don't-care).
- in_pkt flag:
  - set on an accepted beat with tlast=0; cleared on an accepted beat with tlast=1.
  - only changes in ACTIVE.
- idle_cnt (16 bit):
  - in ACTIVE, cleared whenever s_axis_tvalid=1 or in_pkt=1; otherwise increments, saturating at 65535.
  - cleared on every entry to ACTIVE.
- ACTIVE -> SLEEP when all hold: lpi_en=1, s_axis_tvalid=0, in_pkt=0, idle_cnt >= IDLE_CYCLES-1.
  - Entry never splits a packet.
- SLEEP:
  - tx_lpi=1 for exactly TS_CYCLES cycles; never aborted.
  - wake_pend latches 1 if s_axis_tvalid=1 or lpi_en=0 in any SLEEP cycle.
  - On the last cycle: go to WAKE if wake_pend=1 or s_axis_tvalid=1 or lpi_en=0; otherwise go to LPI.
- LPI:
  - tx_lpi=1.
  - Stays until s_axis_tvalid=1 or lpi_en=0, then goes to WAKE on the next edge.
- WAKE:
  - tx_lpi=0 for exactly TW_CYCLES cycles, then ACTIVE.
  - lpi_en changes are ignored.
- State timer (16 bit): cleared on state entry; the state is exited when timer == N-1.
- wake_pend is cleared on SLEEP entry.
- lpi_en=0 while in ACTIVE simply blocks entry.
- Simultaneous s_axis_tvalid=1 and idle threshold reached: tvalid wins and the block stays in ACTIVE.
- Reset mid-operation (any state):
  - returns to ACTIVE next edge.
  - clears idle_cnt, timer, in_pkt, wake_pend.
  - clears statistics.

## Timing
- Reset values:
  - state ACTIVE, lpi_state 00, tx_lpi 0.
  - m_axis_tvalid follows s_axis_tvalid (ACTIVE), s_axis_tready follows m_axis_tready.
  - lpi_cycles 0, lpi_entries 0.
- ACTIVE latency is 0 cycles, combinational; no buffering and no beat loss or duplication.
- tx_lpi and lpi_state are registered, derived from the state register.
- Idle to LPI:
  - after the last accepted tlast beat with tvalid low thereafter, SLEEP begins IDLE_CYCLES+1 edges later.
  - LPI begins TS_CYCLES after that.
- LPI to traffic:
  - s_axis_tvalid seen in LPI at cycle t: WAKE covers t+1 .. t+TW_CYCLES.
  - first beat accepted at t+TW_CYCLES+1 if m_axis_tready=1.
- tvalid seen in SLEEP: SLEEP runs to completion, then TW_CYCLES of WAKE, then ACTIVE.
- Upstream must hold tvalid/data stable while tready=0 (AXI rule). The block does not check this.

## Configuration
- Macro EEE_LPI_STATS_EN.
- Defined:
  - lpi_cycles increments each cycle in LPI, saturating at 2^32-1.
  - lpi_entries increments on each ACTIVE->SLEEP transition, wrapping at 2^16.
  - Both counters are cleared only by reset.
- Undefined:
  - counters are not built.
  - lpi_cycles and lpi_entries are driven constant 0; ports remain present.

## Test plan
Bench parameters: IDLE_CYCLES=8, TS_CYCLES=4, TW_CYCLES=5, EEE_LPI_STATS_EN defined.
- Pass-through:
  - stimulus: 3-beat packet with m_axis_tready=1, lpi_en=1.
  - response: beats on m_axis in the same cycles, bit-identical; lpi_state stays 00.
- Idle entry and exit:
  - stimulus: packet ends, tvalid held 0; later tvalid raised at cycle t while in LPI.
  - response: lpi_state 01 exactly 9 edges after tlast, for 4 cycles, then 10; WAKE (11) for 5 cycles; first beat accepted at t+6; lpi_entries=1.
- Wake during SLEEP:
  - stimulus: tvalid raised in SLEEP cycle 2.
  - response: SLEEP completes 4 cycles, goes straight to WAKE (LPI skipped), s_axis_tready=0 throughout.
- No mid-packet entry:
  - stimulus: first beat without tlast, then 20 cycles of tvalid=0, then last beat.
  - response: lpi_state stays 00; after tlast, SLEEP 9 edges later.
- lpi_en control:
  - stimulus A: lpi_en=0 with 50 idle cycles. Response: no entry.
  - stimulus B: lpi_en dropped in LPI. Response: WAKE next edge, then ACTIVE after 5 cycles.
- Reset mid-LPI:
  - stimulus: axi_reset=1 for 1 cycle while in LPI, after 10 LPI cycles.
  - response: next edge ACTIVE, tx_lpi=0, lpi_cycles=0, lpi_entries=0.

Source files
------------

// File: rtl/nf10_eee_lpi_scheduler.sv
// nf10_eee_lpi_scheduler
// 802.3az low-power-idle sequencer for one 10G TX path. Sits in the AXI4-Stream
// path as a zero-latency gate: traffic passes straight through in ACTIVE and is
// held off (tready=0) while the link sleeps, idles or wakes.
// Optional build macro: EEE_LPI_STATS_EN enables the lpi_cycles / lpi_entries
// counters; without it both ports are tied to zero.
module nf10_eee_lpi_scheduler #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int IDLE_CYCLES   = 64,
    parameter int TS_CYCLES     = 461,
    parameter int TW_CYCLES     = 6349
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,

    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,

    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,

    input  logic                       lpi_en,
    output logic                       tx_lpi,
    output logic [1:0]                 lpi_state,
    output logic [31:0]                lpi_cycles,
    output logic [15:0]                lpi_entries
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_SLEEP  = 2'b01,
        ST_LPI    = 2'b10,
        ST_WAKE   = 2'b11
    } state_t;

    localparam logic [15:0] IDLE_TH = 16'(IDLE_CYCLES - 1);
    localparam logic [15:0] TS_LAST = 16'(TS_CYCLES - 1);
    localparam logic [15:0] TW_LAST = 16'(TW_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] timer;
    logic [15:0] idle_cnt;
    logic        in_pkt;
    logic        wake_pend;
    logic        active;
    logic        wake_req;
    logic        beat_acc;

    assign active   = (state == ST_ACTIVE);
    assign wake_req = s_axis_tvalid | ~lpi_en;
    assign beat_acc = active & s_axis_tvalid & m_axis_tready;

    // Data fields always mirror upstream; only the handshake is gated by state.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = active & s_axis_tvalid;
    assign s_axis_tready = active & m_axis_tready;

    // PHY request and software view are pure decodes of the state register.
    assign tx_lpi    = (state == ST_SLEEP) || (state == ST_LPI);
    assign lpi_state = state;

    // Next-state: entry only between packets; SLEEP always runs its full length.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: if (lpi_en && !s_axis_tvalid && !in_pkt && idle_cnt >= IDLE_TH)
                           state_nxt = ST_SLEEP;
            ST_SLEEP:  if (timer == TS_LAST)
                           state_nxt = (wake_pend || wake_req) ? ST_WAKE : ST_LPI;
            ST_LPI:    if (wake_req)
                           state_nxt = ST_WAKE;
            ST_WAKE:   if (timer == TW_LAST)
                           state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

    // State register.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) state <= ST_ACTIVE;
        else           state <= state_nxt;
    end

    // Dwell timer: restarts on every state change, only advances in timed states.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || state_nxt != state)
            timer <= '0;
        else if (state == ST_SLEEP || state == ST_WAKE)
            timer <= timer + 16'd1;
    end

    // Idle counter: held at zero outside ACTIVE so every ACTIVE entry starts fresh.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || !active || s_axis_tvalid || in_pkt)
            idle_cnt <= '0;
        else if (idle_cnt != 16'hFFFF)
            idle_cnt <= idle_cnt + 16'd1;
    end

    // Packet-boundary tracker so LPI entry never lands mid-packet.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset)     in_pkt <= 1'b0;
        else if (beat_acc) in_pkt <= ~s_axis_tlast;
    end

    // Remembers a wake request seen early in SLEEP so LPI is skipped afterwards.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || (active && state_nxt == ST_SLEEP))
            wake_pend <= 1'b0;
        else if (state == ST_SLEEP && wake_req)
            wake_pend <= 1'b1;
    end

`ifdef EEE_LPI_STATS_EN
    logic [31:0] lpi_cycles_q;
    logic [15:0] lpi_entries_q;

    // Statistics: saturating LPI residency, wrapping entry count; reset-only clear.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            lpi_cycles_q  <= '0;
            lpi_entries_q <= '0;
        end else begin
            if (state == ST_LPI && lpi_cycles_q != 32'hFFFF_FFFF)
                lpi_cycles_q <= lpi_cycles_q + 32'd1;
            if (active && state_nxt == ST_SLEEP)
                lpi_entries_q <= lpi_entries_q + 16'd1;
        end
    end

    assign lpi_cycles  = lpi_cycles_q;
    assign lpi_entries = lpi_entries_q;
`else
    assign lpi_cycles  = '0;
    assign lpi_entries = '0;
`endif

endmodule

// File: tb/tb_nf10_eee_lpi_scheduler.sv
// Bench for nf10_eee_lpi_scheduler: vector table, directed EEE sequences and a
// randomized run, all checked against a cycle-level behavioural model.
module tb_nf10_eee_lpi_scheduler;

    localparam int DW   = 64;
    localparam int UW   = 16;
    localparam int SW   = DW / 8;
    localparam int IDLE = 8;
    localparam int TS   = 4;
    localparam int TW   = 5;
`ifdef EEE_LPI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          axi_aclk = 1'b0;
    logic          axi_reset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          lpi_en, tx_lpi;
    logic [1:0]    lpi_state;
    logic [31:0]   lpi_cycles;
    logic [15:0]   lpi_entries;

    always #5 axi_aclk = ~axi_aclk;

    nf10_eee_lpi_scheduler #(
        .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW),
        .IDLE_CYCLES(IDLE), .TS_CYCLES(TS), .TW_CYCLES(TW)
    ) dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .lpi_en(lpi_en), .tx_lpi(tx_lpi), .lpi_state(lpi_state),
        .lpi_cycles(lpi_cycles), .lpi_entries(lpi_entries)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 ACTIVE, 1 SLEEP, 2 LPI, 3 WAKE; 'left' counts
    // remaining cycles of a timed mode.
    int     m_mode = 0, m_idle = 0, m_left = 0, m_lent = 0;
    bit     m_inpkt = 0, m_pend = 0;
    longint m_lcyc = 0;

    task automatic model_step();
        bit was_in, w;
        if (axi_reset) begin
            m_mode = 0; m_idle = 0; m_left = 0; m_inpkt = 0; m_pend = 0;
            m_lcyc = 0; m_lent = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (lpi_en && !s_axis_tvalid && !m_inpkt && m_idle >= IDLE - 1) begin
                    m_mode = 1; m_left = TS; m_pend = 0; m_idle = 0;
                    m_lent = (m_lent + 1) % 65536;
                end else begin
                    was_in = m_inpkt;
                    if (s_axis_tvalid && m_axis_tready) m_inpkt = !s_axis_tlast;
                    if (s_axis_tvalid || was_in) m_idle = 0;
                    else if (m_idle < 65535) m_idle++;
                end
            end
            1: begin
                w = m_pend || s_axis_tvalid || !lpi_en;
                m_pend = w;
                m_left--;
                if (m_left == 0) begin
                    if (w) begin m_mode = 3; m_left = TW; end
                    else m_mode = 2;
                end
            end
            2: begin
                if (m_lcyc < 64'hFFFF_FFFF) m_lcyc++;
                if (s_axis_tvalid || !lpi_en) begin m_mode = 3; m_left = TW; end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_idle = 0; end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("m_tvalid", m_axis_tvalid, (m_mode == 0) && s_axis_tvalid);
        chk("s_tready", s_axis_tready, (m_mode == 0) && m_axis_tready);
        chk("tx_lpi", tx_lpi, (m_mode == 1) || (m_mode == 2));
        chk("lpi_state", lpi_state, m_mode);
        chk("m_tdata", m_axis_tdata, s_axis_tdata);
        chk("m_tlast_tuser_tstrb", {m_axis_tlast, m_axis_tuser, m_axis_tstrb},
            {s_axis_tlast, s_axis_tuser, s_axis_tstrb});
        chk("lpi_cycles", lpi_cycles, STATS ? m_lcyc : 0);
        chk("lpi_entries", lpi_entries, STATS ? m_lent : 0);
    endtask

    // One clock: check current outputs against the model, advance model, clock.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge axi_aclk);
        @(negedge axi_aclk);
    endtask

    task automatic drive(input bit v, input bit l);
        s_axis_tvalid = v;
        s_axis_tlast  = l;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tuser  = UW'($urandom);
        s_axis_tstrb  = SW'($urandom);
    endtask

    // Cycles spent in state st starting from the current cycle (bounded).
    task automatic count_in(input logic [1:0] st, output int n);
        n = 0;
        #1;
        while (lpi_state == st && n < 300) begin
            cycle();
            n++;
            #1;
        end
        chk("wait_bound", n < 300, 1);
    endtask

    // Edges from the tlast acceptance edge (edge 1) until SLEEP is visible.
    task automatic edges_to_sleep(input string name);
        int e;
        drive(1'b1, 1'b1);
        cycle();
        drive(1'b0, 1'b0);
        e = 1;
        #1;
        while (lpi_state != 2'b01 && e < 300) begin
            cycle();
            e++;
            #1;
        end
        chk(name, e, IDLE + 1);
    endtask

    typedef struct {
        bit          vld, last, en, rdy;
        logic [63:0] d;
        bit          e_mvld, e_srdy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        int thr;
        bit acc;

        tbl[0] = '{1, 0, 1, 1, 64'hA5A5_0000_1111_2222, 1, 1};
        tbl[1] = '{1, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 1, 0};
        tbl[2] = '{1, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 1, 1};
        tbl[3] = '{1, 1, 1, 1, 64'hFFFF_0000_FFFF_0000, 1, 1};
        tbl[4] = '{0, 0, 1, 1, 64'h0,                   0, 1};
        tbl[5] = '{0, 0, 1, 0, 64'h0,                   0, 0};
        tbl[6] = '{1, 1, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 1, 1};
        tbl[7] = '{0, 0, 1, 1, 64'h0,                   0, 1};

        // Reset state: pass-through handshake follows inputs even in reset.
        axi_reset = 1'b1; lpi_en = 1'b1; m_axis_tready = 1'b0;
        drive(1'b1, 1'b0);
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        #1;
        chk("rst_state", lpi_state, 2'b00);
        chk("rst_tx_lpi", tx_lpi, 0);
        chk("rst_mvalid", m_axis_tvalid, 1);
        chk("rst_sready", s_axis_tready, 0);
        cycle();
        axi_reset = 1'b0;
        drive(1'b0, 1'b0);
        m_axis_tready = 1'b1;

        // Pass-through vectors.
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = tbl[i].vld; s_axis_tlast = tbl[i].last;
            s_axis_tdata  = tbl[i].d;   lpi_en       = tbl[i].en;
            m_axis_tready = tbl[i].rdy;
            #1;
            chk("vec_mvalid", m_axis_tvalid, tbl[i].e_mvld);
            chk("vec_sready", s_axis_tready, tbl[i].e_srdy);
            chk("vec_state", lpi_state, 2'b00);
            chk("vec_tdata", m_axis_tdata, tbl[i].d);
            cycle();
        end

        // Idle entry, LPI, wake by traffic.
        lpi_en = 1'b1; m_axis_tready = 1'b1;
        edges_to_sleep("idle_sleep_edges");
        count_in(2'b01, n);
        chk("sleep_len", n, TS);
        chk("lpi_after_sleep", lpi_state, 2'b10);
        repeat (3) cycle();
        drive(1'b1, 1'b1);
        cycle();
        count_in(2'b11, n);
        chk("wake_len", n, TW);
        chk("first_beat_ready", s_axis_tready, 1);
        chk("first_beat_valid", m_axis_tvalid, 1);
        chk("entries_after_first", lpi_entries, STATS ? 1 : 0);
        cycle();
        drive(1'b0, 1'b0);

        // Wake request during SLEEP cycle 2: LPI skipped.
        count_in(2'b00, n);
        cycle();
        drive(1'b1, 1'b1);
        count_in(2'b01, n);
        chk("sleep_len_wake", n + 1, TS);
        chk("skip_lpi", lpi_state, 2'b11);
        count_in(2'b11, n);
        chk("wake_len2", n, TW);
        cycle();
        drive(1'b0, 1'b0);

        // No entry mid-packet.
        drive(1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("midpkt_state", lpi_state, 2'b00);
            cycle();
        end
        edges_to_sleep("midpkt_sleep_edges");
        count_in(2'b01, n);

        // lpi_en dropped in LPI: WAKE next edge, ACTIVE after TW.
        chk("in_lpi", lpi_state, 2'b10);
        lpi_en = 1'b0;
        cycle();
        #1;
        chk("en_drop_wake", lpi_state, 2'b11);
        count_in(2'b11, n);
        chk("en_drop_wake_len", n, TW);
        chk("en_drop_active", lpi_state, 2'b00);

        // lpi_en low blocks entry.
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("en_off_state", lpi_state, 2'b00);
            cycle();
        end

        // Reset during LPI.
        lpi_en = 1'b1;
        count_in(2'b00, n);
        count_in(2'b01, n);
        repeat (10) cycle();
        #1;
        chk("lpi_cycles_10", lpi_cycles, STATS ? 10 : 0);
        axi_reset = 1'b1;
        cycle();
        axi_reset = 1'b0;
        #1;
        chk("rst_lpi_state", lpi_state, 2'b00);
        chk("rst_lpi_tx", tx_lpi, 0);
        chk("rst_lpi_cycles", lpi_cycles, 0);
        chk("rst_lpi_entries", lpi_entries, 0);

        // Randomized traffic with held beats, lpi_en toggling and rare resets.
        acc = 1'b0;
        thr = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) thr = $urandom_range(0, 6);
            if (!s_axis_tvalid || acc)
                drive($urandom_range(0, 9) < thr, $urandom_range(0, 2) == 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) lpi_en = ~lpi_en;
            axi_reset = ($urandom_range(0, 999) == 0);
            acc = s_axis_tvalid && (m_mode == 0) && m_axis_tready;
            cycle();
        end
        axi_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
